vga_sync_receiver: RTL and testbench



---
 rtl/vga_sync_receiver.sv | 200 ++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// Sink-side VGA timing recovery: rebuilds hpos/vpos from an hsync/vsync pair, measures line
// and frame periods and declares lock. VGA_RX_SYNC_WIDTH_CHECK_EN adds sync pulse-width checks.
module vga_sync_receiver #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_BOTTOM    = 10,
    parameter int V_SYNC      = 2,
    parameter int V_TOP       = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic        display_on,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err,
    output logic [10:0] h_total_meas
);
    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int MATCH_W      = $clog2(LOCK_FRAMES + 1);

    // +3: source register, s1 stage and the load itself
    localparam logic [9:0]  H_LOAD     = 10'(H_SYNC_START + 3);
    localparam logic [9:0]  V_LOAD     = 10'(V_SYNC_START);
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_DISP_C   = 10'(H_DISPLAY);
    localparam logic [9:0]  V_DISP_C   = 10'(V_DISPLAY);
    localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_C  = 11'(V_TOTAL);
    localparam logic [10:0] CNT_MAX    = 11'h7FF;
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic               hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
    logic [9:0]         h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [10:0]        line_cnt_q, line_cnt_d, frame_cnt_q, frame_cnt_d, h_meas_q, h_meas_d;
    logic               h_seen_q, h_seen_d, line_bad_seen_q, line_bad_seen_d;
    logic               frame_start_q, sync_err_q, sync_err_d;
    logic               h_rise, v_rise, line_judge, line_bad, frame_bad, any_bad;
    logic [10:0]        frame_total;
    logic               h_width_bad, v_width_bad;

    assign h_rise     = hs_s1_q & ~hs_s2_q;
    assign v_rise     = vs_s1_q & ~vs_s2_q;
    assign line_judge = h_rise & h_seen_q;
    assign any_bad    = line_bad | frame_bad;

    always_comb begin : datapath_next
        h_cnt_d = h_cnt_q + 10'd1;
        if (h_rise)                  h_cnt_d = H_LOAD;
        else if (h_cnt_q == H_LAST)  h_cnt_d = '0;

        v_cnt_d = v_cnt_q;
        if (v_rise)                              v_cnt_d = V_LOAD;
        else if (h_cnt_q == H_LAST && !h_rise)   v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;

        line_cnt_d = (line_cnt_q == CNT_MAX) ? CNT_MAX : line_cnt_q + 11'd1;
        if (h_rise) line_cnt_d = 11'd1;

        // an hsync rise coinciding with the vsync rise closes the ending frame
        frame_total = (frame_cnt_q == CNT_MAX) ? CNT_MAX : frame_cnt_q + 11'(h_rise);
        frame_cnt_d = v_rise ? '0 : frame_total;

        h_seen_d = h_seen_q | h_rise;
        h_meas_d = line_judge ? line_cnt_q : h_meas_q;

        line_bad  = (line_judge & ((line_cnt_q != H_TOTAL_C) | (line_cnt_q == CNT_MAX) | h_width_bad))
                  | (h_seen_q & ~h_rise & (line_cnt_q == CNT_MAX - 11'd1));
        frame_bad = (v_rise & ((frame_total != V_TOTAL_C) | (frame_total == CNT_MAX)
                              | line_bad_seen_q | line_bad | v_width_bad))
                  | (~v_rise & h_rise & (frame_cnt_q == CNT_MAX - 11'd1));
        line_bad_seen_d = v_rise ? 1'b0 : (line_bad_seen_q | line_bad);
    end

    always_ff @(posedge clk) begin : datapath_reg
        if (reset) begin
            hs_s1_q         <= 1'b0;
            hs_s2_q         <= 1'b0;
            vs_s1_q         <= 1'b0;
            vs_s2_q         <= 1'b0;
            h_cnt_q         <= '0;
            v_cnt_q         <= '0;
            line_cnt_q      <= '0;
            frame_cnt_q     <= '0;
            h_meas_q        <= '0;
            h_seen_q        <= 1'b0;
            line_bad_seen_q <= 1'b0;
            frame_start_q   <= 1'b0;
            sync_err_q      <= 1'b0;
        end else begin
            hs_s1_q         <= hsync_in;
            hs_s2_q         <= hs_s1_q;
            vs_s1_q         <= vsync_in;
            vs_s2_q         <= vs_s1_q;
            h_cnt_q         <= h_cnt_d;
            v_cnt_q         <= v_cnt_d;
            line_cnt_q      <= line_cnt_d;
            frame_cnt_q     <= frame_cnt_d;
            h_meas_q        <= h_meas_d;
            h_seen_q        <= h_seen_d;
            line_bad_seen_q <= line_bad_seen_d;
            frame_start_q   <= v_rise;
            sync_err_q      <= sync_err_d;
        end
    end

`ifdef VGA_RX_SYNC_WIDTH_CHECK_EN
    localparam logic [10:0] H_SYNC_C = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_C = 11'(V_SYNC);

    logic [10:0] hs_width_q, hs_width_d, vs_lines_q, vs_lines_d;

    always_comb begin : width_next
        hs_width_d = hs_width_q;
        if (h_rise)                                        hs_width_d = 11'd1;
        else if (hs_s1_q && hs_width_q != CNT_MAX)         hs_width_d = hs_width_q + 11'd1;
        vs_lines_d = vs_lines_q;
        if (v_rise)                                        vs_lines_d = 11'(h_rise);
        else if (vs_s1_q && h_rise && vs_lines_q != CNT_MAX) vs_lines_d = vs_lines_q + 11'd1;
    end

    always_ff @(posedge clk) begin : width_reg
        if (reset) begin
            hs_width_q <= '0;
            vs_lines_q <= '0;
        end else begin
            hs_width_q <= hs_width_d;
            vs_lines_q <= vs_lines_d;
        end
    end

    assign h_width_bad = (hs_width_q != H_SYNC_C);
    assign v_width_bad = (vs_lines_q != V_SYNC_C);
`else
    assign h_width_bad = 1'b0;
    assign v_width_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state_q     <= SEARCH;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    always_comb begin : state_next
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        case (state_q)
            SEARCH: begin
                if (v_rise) begin
                    state_d     = TRACK;
                    match_cnt_d = '0;
                end
            end
            TRACK: begin
                if (any_bad) begin
                    state_d = SEARCH;
                end else if (v_rise) begin
                    if (match_cnt_q == MATCH_LAST) state_d = LOCKED;
                    else                           match_cnt_d = match_cnt_q + MATCH_W'(1);
                end
            end
            LOCKED: begin
                if (any_bad) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin : state_out
        locked     = (state_q == LOCKED);
        sync_err_d = any_bad & (state_q != SEARCH);
    end

    assign hpos         = h_cnt_q;
    assign vpos         = v_cnt_q;
    assign h_total_meas = h_meas_q;
    assign frame_start  = frame_start_q;
    assign sync_err     = sync_err_q;
    assign display_on   = locked & (h_cnt_q < H_DISP_C) & (v_cnt_q < V_DISP_C);

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a shrunken timing set (25 x 11) and a
// behavioural model of the team's registered sync generator.
module tb_vga_sync_receiver;
    localparam int H_DISPLAY = 16, H_FRONT = 2, H_SYNC = 4, H_BACK = 3;
    localparam int V_DISPLAY = 6,  V_BOTTOM = 1, V_SYNC = 2, V_TOP = 2;
    localparam int LOCK_FRAMES = 2;
    localparam int H_TOTAL = 25, V_TOTAL = 11, HSS = 18, VSS = 7;

    logic        clk = 1'b0;
    logic        reset, hsync_in, vsync_in;
    logic [9:0]  hpos, vpos;
    logic        display_on, locked, frame_start, sync_err;
    logic [10:0] h_total_meas;

    int n_assert = 0, n_fail = 0, err_cnt = 0, fs_cnt = 0;
    int gh = 0, gv = 0, line_len = H_TOTAL, frame_len = V_TOTAL, hs_w = H_SYNC;
    bit hs_q = 1'b0, vs_q = 1'b0, chk_align = 1'b0;
    int e0, fs0;

    vga_sync_receiver #(
        .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_DISPLAY(V_DISPLAY), .V_BOTTOM(V_BOTTOM), .V_SYNC(V_SYNC), .V_TOP(V_TOP),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hpos(hpos), .vpos(vpos), .display_on(display_on), .locked(locked),
        .frame_start(frame_start), .sync_err(sync_err), .h_total_meas(h_total_meas)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel clock: sample at negedge, then drive the generator's registered syncs and advance it.
    task automatic tick();
        @(negedge clk);
        if (chk_align) begin
            chk("hpos", 32'(hpos), gh);
            chk("vpos", 32'(vpos), gv);
            chk("display_on", 32'(display_on), (gh < H_DISPLAY && gv < V_DISPLAY) ? 1 : 0);
        end
        if (sync_err === 1'b1) err_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
        hsync_in = hs_q;
        vsync_in = vs_q;
        hs_q = (gh >= HSS) && (gh < HSS + hs_w);
        vs_q = (gv >= VSS) && (gv < VSS + V_SYNC);
        if (gh == line_len - 1) begin
            gh = 0;
            line_len = H_TOTAL;
            hs_w = H_SYNC;
            if (gv == frame_len - 1) begin
                gv = 0;
                frame_len = V_TOTAL;
            end else begin
                gv++;
            end
        end else begin
            gh++;
        end
    endtask

    task automatic wait_vs_rise();
        int found;
        logic prev;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            prev = vsync_in;
            tick();
            if (!prev && vsync_in) begin
                found = 1;
                break;
            end
        end
        chk("vsync_rise_seen", found, 1);
    endtask

    task automatic wait_err(input int bound);
        int found;
        found = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (sync_err === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("sync_err_seen", found, 1);
    endtask

    task automatic wait_gen(input int h, input int v);
        int found;
        found = 0;
        for (int i = 0; i < 600; i++) begin
            if (gh == h && gv == v) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("gen_position_reached", found, 1);
    endtask

    // Lock must appear exactly one edge after the detect of the third vsync rise.
    task automatic relock(input string tag);
        for (int k = 1; k <= LOCK_FRAMES + 1; k++) begin
            wait_vs_rise();
            if (k <= LOCK_FRAMES) chk({tag, "_unlocked_before"}, 32'(locked), 0);
        end
        tick();
        chk({tag, "_unlocked_at_detect"}, 32'(locked), 0);
        tick();
        chk({tag, "_locked"}, 32'(locked), 1);
        chk({tag, "_frame_start"}, 32'(frame_start), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hpos"}, 32'(hpos), 0);
        chk({tag, "_vpos"}, 32'(vpos), 0);
        chk({tag, "_display_on"}, 32'(display_on), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_frame_start"}, 32'(frame_start), 0);
        chk({tag, "_sync_err"}, 32'(sync_err), 0);
        chk({tag, "_h_total_meas"}, 32'(h_total_meas), 0);
    endtask

    initial begin
        reset = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b0;

        // initial acquisition from the generator
        relock("init");
        chk("init_no_err", err_cnt, 0);
        chk("init_meas", 32'(h_total_meas), H_TOTAL);

        // locked tracking over two whole frames
        chk_align = 1'b1;
        fs0 = fs_cnt;
        repeat (2 * H_TOTAL * V_TOTAL) tick();
        chk_align = 1'b0;
        chk("frame_start_per_frame", fs_cnt - fs0, 2);
        chk("track_no_err", err_cnt, 0);
        chk("track_locked", 32'(locked), 1);
        chk("track_meas", 32'(h_total_meas), H_TOTAL);

        // one line one clock too long
        wait_gen(0, 2);
        line_len = H_TOTAL + 1;
        e0 = err_cnt;
        wait_err(3 * H_TOTAL);
        chk("long_line_unlocked", 32'(locked), 0);
        chk("long_line_meas", 32'(h_total_meas), H_TOTAL + 1);
        tick();
        chk("long_line_err_one_cycle", 32'(sync_err), 0);
        relock("long_line");
        chk("long_line_err_count", err_cnt - e0, 1);

        // one frame one line short
        wait_gen(0, 0);
        frame_len = V_TOTAL - 1;
        e0 = err_cnt;
        wait_err(2 * H_TOTAL * V_TOTAL);
        chk("short_frame_unlocked", 32'(locked), 0);
        relock("short_frame");
        chk("short_frame_err_count", err_cnt - e0, 1);

        // hsync one clock narrow on one line
        wait_gen(0, 2);
        hs_w = H_SYNC - 1;
        e0 = err_cnt;
`ifdef VGA_RX_SYNC_WIDTH_CHECK_EN
        wait_err(3 * H_TOTAL);
        chk("narrow_hsync_unlocked", 32'(locked), 0);
        relock("narrow_hsync");
        chk("narrow_hsync_err_count", err_cnt - e0, 1);
`else
        repeat (3 * H_TOTAL) tick();
        chk("narrow_hsync_no_err", err_cnt - e0, 0);
        chk("narrow_hsync_locked", 32'(locked), 1);
`endif

        // reset mid-frame while locked
        chk("pre_reset_locked", 32'(locked), 1);
        wait_gen(5, 3);
        e0 = err_cnt;
        reset = 1'b1;
        tick();
        chk_all_zero("mid_reset");
        reset = 1'b0;
        relock("after_reset");
        chk("after_reset_err_count", err_cnt - e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
